// File: rtl/bp_me_cache_dma_to_mem.sv
// Bridges bsg_cache DMA block transfers onto a single-beat pipelined memory port; optional block counters under BP_ME_CACHE_DMA_PERF_EN.
// Latency: first memory request 1 cycle after packet yumi; read return visible to the cache 1 cycle after mem_data_v_i.
// Backpressure: reads are credit-limited to rd_fifo_els_p in flight so memory returns never stall; writes stall on mem_ready_and_i.
module bp_me_cache_dma_to_mem #(
   parameter int addr_width_p  = 28,
   parameter int fill_width_p  = 64,
   parameter int block_beats_p = 8,
   parameter int rd_fifo_els_p = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic [addr_width_p:0]   dma_pkt_i,
   input  logic                    dma_pkt_v_i,
   output logic                    dma_pkt_yumi_o,
   input  logic [fill_width_p-1:0] dma_data_i,
   input  logic                    dma_data_v_i,
   output logic                    dma_data_yumi_o,
   output logic [fill_width_p-1:0] dma_data_o,
   output logic                    dma_data_v_o,
   input  logic                    dma_data_ready_and_i,
   output logic                    mem_v_o,
   output logic                    mem_w_o,
   output logic [addr_width_p-1:0] mem_addr_o,
   output logic [fill_width_p-1:0] mem_data_o,
   input  logic                    mem_ready_and_i,
   input  logic [fill_width_p-1:0] mem_data_i,
   input  logic                    mem_data_v_i,
   output logic [31:0]             perf_rd_blocks_o,
   output logic [31:0]             perf_wr_blocks_o
);

   localparam int stride_lg_lp = $clog2(fill_width_p/8);
   localparam int block_lg_lp  = stride_lg_lp + $clog2(block_beats_p);
   localparam int beat_w_lp    = $clog2(block_beats_p);
   localparam int ptr_w_lp     = $clog2(rd_fifo_els_p);
   localparam int cnt_w_lp     = $clog2(rd_fifo_els_p+1);

   localparam logic [cnt_w_lp-1:0]     els_lp       = cnt_w_lp'(rd_fifo_els_p);
   localparam logic [beat_w_lp-1:0]    last_beat_lp = beat_w_lp'(block_beats_p-1);
   localparam logic [ptr_w_lp-1:0]     last_ptr_lp  = ptr_w_lp'(rd_fifo_els_p-1);
   localparam logic [addr_width_p-1:0] blk_mask_lp  =
      ~((addr_width_p'(1) << block_lg_lp) - addr_width_p'(1));

   typedef enum logic [1:0] {IDLE_S, RD_REQ_S, RD_DRAIN_S, WR_REQ_S} state_e;

   state_e                  state_q,   state_d;
   logic [addr_width_p-1:0] base_q,    base_d;
   logic [beat_w_lp-1:0]    beat_q,    beat_d;
   logic [cnt_w_lp-1:0]     credits_q, credits_d;
   logic [cnt_w_lp-1:0]     count_q,   count_d;
   logic [ptr_w_lp-1:0]     rptr_q,    rptr_d;
   logic [ptr_w_lp-1:0]     wptr_q,    wptr_d;
   logic [fill_width_p-1:0] mem_q [rd_fifo_els_p];

   logic is_rd_req, is_wr_req, rd_active, is_last;
   logic mem_fire, rd_fire, fifo_full, fifo_empty, enq, deq;

   assign is_rd_req  = (state_q == RD_REQ_S);
   assign is_wr_req  = (state_q == WR_REQ_S);
   assign rd_active  = is_rd_req | (state_q == RD_DRAIN_S);
   assign is_last    = (beat_q == last_beat_lp);
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == els_lp);

   // Reads only issue with a free return slot; writes forward the cache beat straight through.
   assign mem_v_o    = (is_rd_req & (credits_q != '0)) | (is_wr_req & dma_data_v_i);
   assign mem_w_o    = is_wr_req;
   assign mem_addr_o = base_q + (addr_width_p'(beat_q) << stride_lg_lp);
   assign mem_data_o = dma_data_i;
   assign mem_fire   = mem_v_o & mem_ready_and_i;
   assign rd_fire    = mem_fire & is_rd_req;

   assign dma_pkt_yumi_o  = reset_n_i & (state_q == IDLE_S) & dma_pkt_v_i;
   assign dma_data_yumi_o = mem_fire & is_wr_req;

   // Returns are not bypassed: they land in storage and show up the following cycle.
   assign deq          = ~fifo_empty & dma_data_ready_and_i;
   assign enq          = mem_data_v_i & rd_active & (~fifo_full | deq);
   assign dma_data_v_o = ~fifo_empty;
   assign dma_data_o   = mem_q[rptr_q];

   // Next-state for the transfer FSM, beat counter, credits and return FIFO pointers.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      beat_d    = beat_q;
      credits_d = credits_q + cnt_w_lp'(deq) - cnt_w_lp'(rd_fire);
      count_d   = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      if (enq) wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + ptr_w_lp'(1);
      if (deq) rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + ptr_w_lp'(1);
      case (state_q)
         IDLE_S: begin
            if (dma_pkt_yumi_o) begin
               base_d  = dma_pkt_i[addr_width_p-1:0] & blk_mask_lp;
               beat_d  = '0;
               state_d = dma_pkt_i[addr_width_p] ? WR_REQ_S : RD_REQ_S;
            end
         end
         RD_REQ_S: begin
            if (rd_fire) begin
               beat_d = beat_q + beat_w_lp'(1);
               if (is_last) state_d = RD_DRAIN_S;
            end
         end
         // All credits home means nothing in flight and nothing left in the FIFO.
         RD_DRAIN_S: begin
            if (credits_q == els_lp) state_d = IDLE_S;
         end
         WR_REQ_S: begin
            if (mem_fire) begin
               beat_d = beat_q + beat_w_lp'(1);
               if (is_last) state_d = IDLE_S;
            end
         end
         default: state_d = IDLE_S;
      endcase
   end

   // State registers; reset clears everything at once, including any burst in flight.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= IDLE_S;
         base_q    <= '0;
         beat_q    <= '0;
         credits_q <= els_lp;
         count_q   <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         for (int i = 0; i < rd_fifo_els_p; i++) mem_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         beat_q    <= beat_d;
         credits_q <= credits_d;
         count_q   <= count_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         if (enq) mem_q[wptr_q] <= mem_data_i;
      end
   end

   a_credit_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(rd_fire && !deq && credits_q == '0));
   a_credit_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(deq && !rd_fire && credits_q == els_lp));
   a_fifo_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(mem_data_v_i && fifo_full && !deq));
   a_stray_return: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(mem_data_v_i && !rd_active));

`ifdef BP_ME_CACHE_DMA_PERF_EN
   logic [31:0] perf_rd_q, perf_wr_q;
   logic        rd_done, wr_done;

   assign rd_done = (state_q == RD_DRAIN_S) & (credits_q == els_lp);
   assign wr_done = dma_data_yumi_o & is_last;

   // Saturating block counters.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         perf_rd_q <= '0;
         perf_wr_q <= '0;
      end else begin
         if (rd_done && perf_rd_q != 32'hFFFF_FFFF) perf_rd_q <= perf_rd_q + 32'd1;
         if (wr_done && perf_wr_q != 32'hFFFF_FFFF) perf_wr_q <= perf_wr_q + 32'd1;
      end
   end

   assign perf_rd_blocks_o = perf_rd_q;
   assign perf_wr_blocks_o = perf_wr_q;
`else
   assign perf_rd_blocks_o = '0;
   assign perf_wr_blocks_o = '0;
`endif

endmodule
